// File: rtl/tube_nc.sv
// tube_nc: elastic execution tube; the op result is computed at entry and carried through DEPTH stages.
// Latency: DEPTH cycles from input transfer to out_valid when unstalled; one entry per cycle throughput.
// Backpressure: per-stage valid/ready with bubble collapse; in_ready follows out_ready combinationally.
module tube_nc #(
    parameter int REG_WIDTH = 32,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_WIDTH-1:0] in_data1,
    input  logic [REG_WIDTH-1:0] in_data2,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] occupancy
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_PACK = 2'd2,
        OP_XOR  = 2'd3
    } op_e;

    logic [DEPTH-1:0]     r_vld;
    logic [REG_WIDTH-1:0] r_dat [DEPTH];
    logic [CNT_WIDTH-1:0] r_occ;

    logic [DEPTH-1:0]     w_ld;
    logic                 w_chain;
    logic [REG_WIDTH-1:0] w_result;
    logic                 w_in_xfer;
    logic                 w_out_xfer;

    // Compute the result once, at entry; later stages only carry it.
    always_comb begin
        w_result = '0;
        case (op_e'(op))
            OP_ADD:  w_result = in_data1 + in_data2;
            OP_SUB:  w_result = in_data1 - in_data2;
            OP_PACK: w_result = (in_data1 << 8) | in_data2;
            OP_XOR:  w_result = in_data1 ^ in_data2;
            default: w_result = '0;
        endcase
    end

    // Stage i loads when it is empty or its successor advances; walking from the
    // output backwards, any hole downstream lets every stage behind it move up.
    always_comb begin
        w_ld    = '0;
        w_chain = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_chain = w_chain | !r_vld[i];
            w_ld[i] = w_chain;
        end
    end

    assign in_ready   = w_ld[0] & !flush & rst;
    assign out_valid  = r_vld[DEPTH-1] & !flush;
    assign out_data   = r_dat[DEPTH-1];
    assign occupancy  = r_occ;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    // Stage registers: reset clears everything, flush clears only the valid bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dat[i] <= '0;
            end
        end else if (flush) begin
            r_vld <= '0;
        end else begin
            if (w_ld[0]) begin
                r_vld[0] <= in_valid;
                r_dat[0] <= w_result;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_ld[i]) begin
                    r_vld[i] <= r_vld[i-1];
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    // Occupancy tracks input minus output transfers; simultaneous ones cancel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + CNT_WIDTH'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_tube_nc.sv
// tb_tube_nc: directed stimulus on three tube depths (8, 4, 1) with a scoreboard per instance.
// Expected results are hand-computed and queued on each input transfer; a negedge monitor pops them.
// Flush and reset empty the queues, so any stale result emerging afterwards is flagged.
module tb_tube_nc;

    typedef struct {
        logic [31:0] d;
        int          c;
    } ent_t;

    localparam logic [31:0] VA [10] = '{32'hFFFFFFFF, 32'h00000000, 32'hAB00CDEF, 32'hF0F0F0F0, 32'h7FFFFFFF,
                                        32'h12345678, 32'd100,      32'hA5A5A5A5, 32'h00001234, 32'h00000010};
    localparam logic [31:0] VB [10] = '{32'h00000002, 32'h00000001, 32'h00000055, 32'h0FF00FF0, 32'h00000001,
                                        32'h000001FF, 32'd58,       32'hFFFFFFFF, 32'h00004321, 32'h00000020};
    localparam logic [1:0]  VO [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd1};
    localparam logic [31:0] VE [10] = '{32'h00000001, 32'hFFFFFFFF, 32'h00CDEF55, 32'hFF00FF00, 32'h80000000,
                                        32'h345679FF, 32'h0000002A, 32'h5A5A5A5A, 32'h00005555, 32'hFFFFFFF0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;

    logic iv8 = 0, ir8, ov8, or8 = 0;
    logic [31:0] a8 = 0, b8 = 0, od8, e8 = 0;
    logic [1:0] op8 = 0;
    logic [3:0] occ8;

    logic iv4 = 0, ir4, ov4, or4 = 0;
    logic [31:0] a4 = 0, b4 = 0, od4, e4 = 0;
    logic [1:0] op4 = 0;
    logic [2:0] occ4;

    logic iv1 = 0, ir1, ov1, or1 = 0;
    logic [31:0] a1 = 0, b1 = 0, od1, e1 = 0;
    logic [1:0] op1 = 0;
    logic [0:0] occ1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc4 = 0;
    int pk;
    bit mon_en = 0;
    bit lat8 = 0;

    ent_t q8[$], q4[$], q1[$];
    ent_t t8, t4, t1;

    tube_nc #(.REG_WIDTH(32), .DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv8), .in_ready(ir8),
        .in_data1(a8), .in_data2(b8), .op(op8), .out_valid(ov8), .out_ready(or8),
        .out_data(od8), .occupancy(occ8));

    tube_nc #(.REG_WIDTH(32), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv4), .in_ready(ir4),
        .in_data1(a4), .in_data2(b4), .op(op4), .out_valid(ov4), .out_ready(or4),
        .out_data(od4), .occupancy(occ4));

    tube_nc #(.REG_WIDTH(32), .DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv1), .in_ready(ir1),
        .in_data1(a1), .in_data2(b1), .op(op1), .out_valid(ov1), .out_ready(or1),
        .out_data(od1), .occupancy(occ1));

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry to instance d and hold it until accepted; call at posedge+1.
    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] o, input logic [31:0] e);
        int k;
        case (d)
            8: begin iv8 = 1; a8 = a; b8 = b; op8 = o; e8 = e; end
            4: begin iv4 = 1; a4 = a; b4 = b; op4 = o; e4 = e; end
            default: begin iv1 = 1; a1 = a; b1 = b; op1 = o; e1 = e; end
        endcase
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if ((d == 8 && ir8) || (d == 4 && ir4) || (d == 1 && ir1)) break;
        end
        chk("send_accepted", (k < 300), 1);
        step();
        case (d)
            8: iv8 = 0;
            4: iv4 = 0;
            default: iv1 = 0;
        endcase
    endtask

    // Scoreboard monitor: compare outputs, then queue newly accepted entries.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("occ8", occ8, q8.size());
            if (ov8 && or8) begin
                chk("sb8_pending", (q8.size() != 0), 1);
                if (q8.size() != 0) begin
                    t8 = q8.pop_front();
                    chk("data8", od8, t8.d);
                    if (lat8) chk("lat8", cyc - t8.c, 8);
                end
            end
            if (iv8 && ir8) q8.push_back('{d: e8, c: cyc});
            if (!rst || flush) q8.delete();

            chk("occ4", occ4, q4.size());
            if (ov4 && or4) begin
                chk("sb4_pending", (q4.size() != 0), 1);
                if (q4.size() != 0) begin
                    t4 = q4.pop_front();
                    chk("data4", od4, t4.d);
                end
            end
            if (iv4 && ir4) begin
                q4.push_back('{d: e4, c: cyc});
                acc4++;
            end
            if (!rst || flush) q4.delete();

            chk("occ1", occ1, q1.size());
            if (rst && !flush) chk("ir1", ir1, (!ov1) | or1);
            if (ov1 && or1) begin
                chk("sb1_pending", (q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    t1 = q1.pop_front();
                    chk("data1", od1, t1.d);
                end
            end
            if (iv1 && ir1) q1.push_back('{d: e1, c: cyc});
            if (!rst || flush) q1.delete();
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ov8", ov8, 0);
        chk("rst_od8", od8, 0);
        chk("rst_occ8", occ8, 0);
        chk("rst_ir8", ir8, 0);
        chk("rst_occ4", occ4, 0);
        chk("rst_ov1", ov1, 0);
        step();
        rst = 1;
        @(negedge clk);
        chk("post_rst_ir8", ir8, 1);
        chk("post_rst_ir4", ir4, 1);
        chk("post_rst_ir1", ir1, 1);
        mon_en = 1;
        step();

        // DEPTH=8 back-to-back ops with out_ready held high
        or8 = 1;
        lat8 = 1;
        send(8, 32'd5, 32'd3, 2'd0, 32'd8);
        send(8, 32'd3, 32'd5, 2'd1, 32'hFFFFFFFE);
        send(8, 32'h12, 32'h34, 2'd2, 32'h1234);
        pk = 0;
        repeat (12) begin
            @(negedge clk);
            if (int'(occ8) > pk) pk = int'(occ8);
        end
        chk("peak_occ8", pk, 3);
        step();

        // DEPTH=4 stalled output: exactly four accepted, then drain in order
        fork
            begin
                for (int i = 1; i <= 6; i++) send(4, i, 32'd0, 2'd3, i);
            end
            begin
                repeat (9) @(negedge clk);
                chk("stall_ir4", ir4, 0);
                chk("stall_occ4", occ4, 4);
                chk("stall_acc4", acc4, 4);
                step();
                or4 = 1;
            end
        join
        repeat (10) step();

        // DEPTH=4 full tube streaming: one in, one out per cycle
        or4 = 0;
        for (int i = 0; i < 4; i++) send(4, VA[i], VB[i], VO[i], VE[i]);
        or4 = 1;
        fork
            begin
                for (int i = 4; i < 10; i++) send(4, VA[i], VB[i], VO[i], VE[i]);
            end
            begin
                repeat (6) begin
                    @(negedge clk);
                    chk("full_occ4", occ4, 4);
                    chk("full_ir4", ir4, 1);
                    chk("full_ov4", ov4, 1);
                end
            end
        join
        repeat (8) step();

        // DEPTH=8 flush with three entries in flight
        send(8, 32'd1, 32'd1, 2'd0, 32'd2);
        send(8, 32'd7, 32'd2, 2'd1, 32'd5);
        send(8, 32'h3, 32'h6, 2'd3, 32'h5);
        flush = 1;
        iv8 = 1; a8 = 32'd9; b8 = 32'd9; op8 = 2'd0; e8 = 32'd18;
        @(negedge clk);
        chk("flush_ir8", ir8, 0);
        chk("flush_ov8", ov8, 0);
        step();
        flush = 0;
        iv8 = 0;
        @(negedge clk);
        chk("flush_occ8", occ8, 0);
        repeat (8) begin
            chk("flush_quiet_ov8", ov8, 0);
            @(negedge clk);
        end
        step();
        send(8, 32'h0F, 32'hF0, 2'd3, 32'hFF);
        repeat (10) step();

        // DEPTH=1 with alternating out_ready
        or1 = 0;
        send(1, 32'd5, 32'd3, 2'd0, 32'd8);
        @(negedge clk);
        chk("d1_lat_vld", ov1, 1);
        chk("d1_lat_dat", od1, 8);
        step();
        fork
            begin
                for (int i = 0; i < 6; i++) send(1, VA[i], VB[i], VO[i], VE[i]);
            end
            begin
                repeat (21) begin
                    or1 = ~or1;
                    step();
                end
            end
        join
        or1 = 1;
        repeat (5) step();

        // DEPTH=8 reset mid-stream with five entries packed against a stalled output
        lat8 = 0;
        or8 = 0;
        for (int i = 21; i <= 25; i++) send(8, i, 32'd0, 2'd3, i);
        repeat (2) step();
        rst = 0;
        @(negedge clk);
        chk("midrst_ir8", ir8, 0);
        step();
        rst = 1;
        @(negedge clk);
        chk("midrst_ov8", ov8, 0);
        chk("midrst_od8", od8, 0);
        chk("midrst_occ8", occ8, 0);
        chk("midrst_ir8_back", ir8, 1);
        step();
        or8 = 1;
        repeat (12) step();

        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
